// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map (unchanged from the
// 4-bit combinational ALU) and the controller state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'b000,
    OP_NAND = 3'b001,
    OP_XOR  = 3'b010,
    OP_MUL  = 3'b011,
    OP_ADD  = 3'b100,
    OP_INC  = 3'b101,
    OP_SUB  = 3'b110,
    OP_SHR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Operand and result handshake bundle for seq_alu. The master is the
// operand source plus result consumer; the slave is the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           S;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   R;

  modport master (
    output in_valid, S, A, B, out_ready,
    input  in_ready, out_valid, R
  );

  modport slave (
    input  in_valid, S, A, B, out_ready,
    output in_ready, out_valid, R
  );
endinterface

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, LSB of b
// first. product is valid (combinationally) in the cycle done is high.
module shift_add_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic [2*WIDTH-1:0] acc_nxt;

  // The final step's sum is exposed directly so the controller can capture
  // the product on the same edge that retires the last step.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign product = acc_nxt;
  assign done    = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      busy   <= !done;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready operand and result handshakes; MUL runs
// WIDTH cycles on shift_add_mul. Optional flag outputs under ALU_FLAGS_EN.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  seq_alu_if.slave    bus
`ifdef ALU_FLAGS_EN
  ,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v
`endif
);
  fsm_state_e         state;
  alu_op_e            op;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] alu_res;

  function automatic logic [2*WIDTH-1:0] alu_exec(alu_op_e f,
                                                  logic [WIDTH-1:0] a,
                                                  logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    r = '0;
    case (f)
      OP_OR:   r[WIDTH-1:0] = a | b;
      OP_NAND: r[WIDTH-1:0] = ~(a & b);
      OP_XOR:  r[WIDTH-1:0] = a ^ b;
      OP_ADD:  r[WIDTH:0]   = {1'b0, a} + {1'b0, b};
      OP_INC:  r[WIDTH:0]   = {1'b0, a} + (WIDTH+1)'(1);
      // Top bit of the widened difference is the borrow.
      OP_SUB:  r[WIDTH:0]   = {1'b0, a} - {1'b0, b};
      // A logical shift by b >= WIDTH already yields zero.
      OP_SHR:  r[WIDTH-1:0] = a >> b;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic ovf_exec(alu_op_e f,
                                    logic signed [WIDTH-1:0] a,
                                    logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] s;
    logic v;
    v = 1'b0;
    if (f == OP_ADD) begin
      s = a + b;
      v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else if (f == OP_SUB) begin
      s = a - b;
      v = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
    return v;
  endfunction
`endif

  assign op        = alu_op_e'(bus.S);
  assign accept    = (state == IDLE) && bus.in_valid;
  assign mul_start = accept && (op == OP_MUL);
  assign alu_res   = alu_exec(op, bus.A, bus.B);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.R         <= '0;
`ifdef ALU_FLAGS_EN
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      flag_v        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (op == OP_MUL) begin
              state <= MUL;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.R         <= alu_res;
`ifdef ALU_FLAGS_EN
              flag_z <= (alu_res == '0);
              flag_c <= (op == OP_ADD || op == OP_INC || op == OP_SUB) ?
                        alu_res[WIDTH] : 1'b0;
              flag_v <= ovf_exec(op, bus.A, bus.B);
`endif
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.R         <= mul_product;
`ifdef ALU_FLAGS_EN
            flag_z <= (mul_product == '0);
            flag_c <= 1'b0;
            flag_v <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=4 (flag checks when
// ALU_FLAGS_EN is defined).
module tb_seq_alu;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  seq_alu_if #(.WIDTH(W)) bus ();

`ifdef ALU_FLAGS_EN
  logic flag_z, flag_c, flag_v;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_v (flag_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, waits for the result, checks latency and R, then drains.
  task automatic run_op(input string tag, input logic [2:0] s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_r, input int exp_lat);
    int lat;
    bus.S = s; bus.A = a; bus.B = b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.A = '1; bus.B = '1; bus.S = 3'b000;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_R"}, 32'(bus.R), 32'(exp_r));
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.S = 3'b000; bus.A = '0; bus.B = '0;
    reset = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_R", 32'(bus.R), 32'd0);
    reset = 1'b1;
    tick();

    run_op("add_9_8", 3'b100, 4'd9, 4'd8, 8'h11, 1);
    drain("add_9_8");
    run_op("mul_15_15", 3'b011, 4'd15, 4'd15, 8'hE1, 5);
    drain("mul_15_15");
    run_op("mul_0_13", 3'b011, 4'd0, 4'd13, 8'h00, 5);
    drain("mul_0_13");
    run_op("mul_3_5", 3'b011, 4'd3, 4'd5, 8'h0F, 5);
    drain("mul_3_5");
    run_op("sub_3_5", 3'b110, 4'd3, 4'd5, 8'h1E, 1);
    drain("sub_3_5");
    run_op("sub_5_3", 3'b110, 4'd5, 4'd3, 8'h02, 1);
    drain("sub_5_3");
    run_op("inc_15", 3'b101, 4'd15, 4'd0, 8'h10, 1);
    drain("inc_15");
    run_op("add_15_15", 3'b100, 4'd15, 4'd15, 8'h1E, 1);
    drain("add_15_15");
    run_op("shr_c_2", 3'b111, 4'hC, 4'd2, 8'h03, 1);
    drain("shr_c_2");
    run_op("shr_c_7", 3'b111, 4'hC, 4'd7, 8'h00, 1);
    drain("shr_c_7");
    run_op("shr_f_4", 3'b111, 4'hF, 4'd4, 8'h00, 1);
    drain("shr_f_4");
    run_op("shr_8_3", 3'b111, 4'h8, 4'd3, 8'h01, 1);
    drain("shr_8_3");
    run_op("nand_c_a", 3'b001, 4'hC, 4'hA, 8'h07, 1);
    drain("nand_c_a");
    run_op("xor_c_a", 3'b010, 4'hC, 4'hA, 8'h06, 1);
    drain("xor_c_a");

    // Backpressure: result must hold while a new request is presented.
    run_op("or_5_a", 3'b000, 4'h5, 4'hA, 8'h0F, 1);
    bus.S = 3'b100; bus.A = 4'd1; bus.B = 4'd1; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_R", 32'(bus.R), 32'h0F);
      chk("bp_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    drain("bp");
    chk("bp_R_hold", 32'(bus.R), 32'h0F);

    // Reset during the second cycle of a MUL aborts it.
    bus.S = 3'b011; bus.A = 4'd15; bus.B = 4'd15; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_ov", 32'(bus.out_valid), 32'd0);
    chk("abort_R", 32'(bus.R), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd1);
    #2;
    reset = 1'b1;
    tick();
    run_op("add_1_1", 3'b100, 4'd1, 4'd1, 8'h02, 1);
    drain("add_1_1");
    // A stale MUL must not reappear after the abort.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_quiet", 32'(bus.out_valid), 32'd0);
    end

`ifdef ALU_FLAGS_EN
    run_op("add_7_1", 3'b100, 4'd7, 4'd1, 8'h08, 1);
    chk("add_7_1_v", 32'(flag_v), 32'd1);
    chk("add_7_1_c", 32'(flag_c), 32'd0);
    chk("add_7_1_z", 32'(flag_z), 32'd0);
    drain("add_7_1");
    run_op("xor_5_5", 3'b010, 4'd5, 4'd5, 8'h00, 1);
    chk("xor_5_5_z", 32'(flag_z), 32'd1);
    chk("xor_5_5_c", 32'(flag_c), 32'd0);
    drain("xor_5_5");
    run_op("sub_3_5f", 3'b110, 4'd3, 4'd5, 8'h1E, 1);
    chk("sub_3_5_c", 32'(flag_c), 32'd1);
    chk("sub_3_5_v", 32'(flag_v), 32'd0);
    drain("sub_3_5f");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU, keeping the same 3-bit opcode map.
- Operand width is `WIDTH`. Operands enter through a valid/ready handshake, and the result leaves through a valid/ready handshake.
- MUL is a multi-cycle shift-add. All other ops complete in one cycle.
- Sits between an operand source (register file or test sequencer) and a result consumer.

Parameters:
- WIDTH, 4, operand width in bits; must be ≥2. Result width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept a new op
- S  input  3  opcode
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  R holds a completed result
- out_ready  input  1  consumer accepts R
- R  output  2*WIDTH  result

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, R=0, multiplier accumulator/counter=0.
- Opcodes: 000 OR, 001 NAND, 010 XOR, 011 MUL, 100 ADD, 101 INC, 110 SUB, 111 SHR.
- Accept: occurs on a clk edge with in_valid && in_ready. A, B and S are captured; the source may then change them freely.
- in_ready is 1 only in IDLE. There is no overlap of operations.
- FSM states: IDLE, MUL, DONE.
  - IDLE, accept of a non-MUL op: R is registered, go to DONE. out_valid=1 on the cycle after accept (latency 1).
  - IDLE, accept of MUL: clear accumulator and counter, go to MUL.
  - MUL: one partial-product step per cycle, LSB of B first. After exactly WIDTH steps, go to DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE: R and out_valid hold stable until out_ready=1. On that edge go to IDLE, out_valid=0, R holds its last value.
- Width rules (upper bits of R are zero unless stated):
  - OR / NAND / XOR: bitwise on WIDTH bits.
  - ADD: R[WIDTH:0] = A+B; R[WIDTH] is the carry-out.
  - INC: R[WIDTH:0] = A+1; A=all-ones gives R[WIDTH]=1, low bits 0.
  - SUB: R[WIDTH-1:0] = A−B modulo 2^WIDTH; R[WIDTH] = borrow (A<B).
  - SHR: logical shift of A right by B; B ≥ WIDTH gives 0.
  - MUL: unsigned, full 2*WIDTH product.
- in_valid while busy: ignored; the source must hold its op until in_ready.
- Reset mid-MUL or in DONE: abort immediately to reset values. The pending result is lost.
- Undefined/X opcode is never produced: all 8 codes are defined.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - Adds output ports flag_z, flag_c, flag_v, each 1-bit.
  - Registered alongside R and valid while out_valid=1.
  - flag_z = (R==0).
  - flag_c = R[WIDTH] for ADD/INC/SUB, 0 otherwise.
  - flag_v = signed overflow on WIDTH bits for ADD/SUB, 0 otherwise.
  - Reset value of all flags is 0.
- Undefined: the ports are absent and there is no flag logic.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_e (OP_OR … OP_SHR, with the codes above).
  - typedef enum fsm_state_e {IDLE, MUL, DONE}.
- Sub-module shift_add_mul:
  - Holds the accumulator, the shifted multiplicand/multiplier and the step counter.
  - Ports: start, a, b, done, product.
  - Parametrised by WIDTH.
- seq_alu holds the FSM, handshakes, single-cycle datapath and the result/flag registers.

Test Plan (WIDTH=4):
- ADD A=9, B=8, accepted in cycle 0 → cycle 1: out_valid=1, R=0x11 (carry=1); with out_ready=1, in_ready=1 in cycle 2.
- MUL A=15, B=15 → in_ready=0 for 4 cycles; out_valid in cycle 5 with R=0xE1. Also MUL 0×13 → R=0x00.
- SUB A=3, B=5 → R=0x1E (borrow=1, low nibble 0xE). INC A=15 → R=0x10. SHR A=0xC, B=2 → R=0x03. SHR B=7 → R=0x00.
- Backpressure: OR A=5, B=A with out_ready=0 for 10 cycles → R=0x0F held stable; new in_valid ignored; drops only after out_ready.
- Assert reset during cycle 2 of a MUL → out_valid=0, R=0, in_ready=1 immediately; the next ADD 1+1 gives R=0x02.
- With ALU_FLAGS_EN: ADD 7+1 → flag_v=1, flag_c=0. XOR A=A → flag_z=1.
